alu_dispatch: RTL and testbench

ID/EX issue stage that feeds the pipelined CPU's 32-bit ALU. It decodes RV32I instruction fields into the ALU's 10-bit one-hot operation code and selects operands. It holds them in the ID/EX pipeline register, then consumes the ALU's 4-bit flag vector in EX to resolve conditional branches and jumps and to drive the fetch redirect.

---
 rtl/alu_pkg.sv | 74 +++++++
 rtl/alu_dispatch_if.sv | 36 +++
 rtl/alu_dispatch_imm_gen.sv | 19 +
 rtl/alu_dispatch.sv | 157 +++++++++++++++
 tb/tb_alu_dispatch.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU dispatch stage: one-hot ALU ops, RV32I opcodes,
// branch funct3 codes, flag indices and the ID/EX register layout.
package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [9:0] ALU_PASS = 10'h000;
   localparam logic [9:0] ALU_ADD  = 10'h001;
   localparam logic [9:0] ALU_SUB  = 10'h002;
   localparam logic [9:0] ALU_SLL  = 10'h004;
   localparam logic [9:0] ALU_SLT  = 10'h008;
   localparam logic [9:0] ALU_SLTU = 10'h010;
   localparam logic [9:0] ALU_XOR  = 10'h020;
   localparam logic [9:0] ALU_SRL  = 10'h040;
   localparam logic [9:0] ALU_SRA  = 10'h080;
   localparam logic [9:0] ALU_OR   = 10'h100;
   localparam logic [9:0] ALU_AND  = 10'h200;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam int FLAG_ZERO = 0;
   localparam int FLAG_SIGN = 1;
   localparam int FLAG_LTU  = 2;
   localparam int FLAG_OVF  = 3;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [9:0]      op;
      logic [4:0]      rd;
      logic            wen;
      logic            is_load;
      logic            is_store;
      logic            illegal;
      logic            is_branch;
      logic            is_jump;
      logic [2:0]      f3;
      logic [XLEN-1:0] target;
   } ex_reg_t;

   // Register-register and immediate ALU ops share funct3; only OP has a SUB form.
   function automatic logic [9:0] alu_op_f3(input logic [2:0] f3, input logic alt,
                                            input logic is_reg);
      logic [9:0] op;
      case (f3)
         3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// ID-side issue and EX-side ALU/redirect signals of the dispatch stage.
interface alu_dispatch_if;
   import alu_pkg::*;

   logic            id_valid;
   logic            id_ready;
   logic [31:0]     id_instr;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic            ex_stall;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [9:0]      alu_op;
   logic [3:0]      alu_signal;
   logic            ex_valid;
   logic [4:0]      ex_rd;
   logic            ex_wen;
   logic            ex_is_load;
   logic            ex_is_store;
   logic            ex_illegal;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   modport master (
      output id_valid, id_instr, id_pc, id_rs1_data, id_rs2_data, ex_stall, alu_signal,
      input  id_ready, alu_a, alu_b, alu_op, ex_valid, ex_rd, ex_wen, ex_is_load,
             ex_is_store, ex_illegal, redirect_valid, redirect_pc
   );

   modport slave (
      input  id_valid, id_instr, id_pc, id_rs1_data, id_rs2_data, ex_stall, alu_signal,
      output id_ready, alu_a, alu_b, alu_op, ex_valid, ex_rd, ex_wen, ex_is_load,
             ex_is_store, ex_illegal, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/alu_dispatch_imm_gen.sv
// RV32I immediate extraction: sign-extended I/S/B/U/J immediates from one word.
module imm_gen (
   input  logic [31:0] instr,
   output logic [31:0] imm_i,
   output logic [31:0] imm_s,
   output logic [31:0] imm_b,
   output logic [31:0] imm_u,
   output logic [31:0] imm_j
);
   logic unused_opcode;

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   assign unused_opcode = ^instr[6:0];
endmodule

// File: rtl/alu_dispatch.sv
// ID/EX issue stage: decodes RV32I into one-hot ALU ops, resolves branches from ALU flags.
// Optional branch statistics counters are enabled by defining ALU_BRANCH_CNT_EN.
module alu_dispatch
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   alu_dispatch_if.slave bus
`ifdef ALU_BRANCH_CNT_EN
   ,
   output logic [31:0] branch_cnt,
   output logic [31:0] taken_cnt
`endif
);
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            funct7_alt;
   logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] jalr_sum;
   ex_reg_t         dec;
   ex_reg_t         ex_reg;
   logic            taken;
   logic            redirect;
   logic            unused_flags;

   assign opcode     = bus.id_instr[6:0];
   assign funct3     = bus.id_instr[14:12];
   assign funct7_alt = bus.id_instr[30];
   assign jalr_sum   = bus.id_rs1_data + imm_i;

   imm_gen u_imm_gen (
      .instr (bus.id_instr),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_b (imm_b),
      .imm_u (imm_u),
      .imm_j (imm_j)
   );

   always_comb begin
      dec       = '0;
      dec.valid = 1'b1;
      dec.rd    = bus.id_instr[11:7];
      dec.f3    = funct3;
      case (opcode)
         OPC_OP: begin
            dec.a   = bus.id_rs1_data;
            dec.b   = bus.id_rs2_data;
            dec.op  = alu_op_f3(funct3, funct7_alt, 1'b1);
            dec.wen = 1'b1;
         end
         OPC_OP_IMM: begin
            dec.a   = bus.id_rs1_data;
            dec.b   = (funct3 == 3'b001 || funct3 == 3'b101) ?
                      {27'b0, bus.id_instr[24:20]} : imm_i;
            dec.op  = alu_op_f3(funct3, funct7_alt, 1'b0);
            dec.wen = 1'b1;
         end
         OPC_LUI: begin
            dec.op  = ALU_PASS;
            dec.b   = imm_u;
            dec.wen = 1'b1;
         end
         OPC_AUIPC: begin
            dec.op  = ALU_ADD;
            dec.a   = bus.id_pc;
            dec.b   = imm_u;
            dec.wen = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            dec.op      = ALU_ADD;
            dec.a       = bus.id_pc;
            dec.b       = 32'd4;
            dec.wen     = 1'b1;
            dec.is_jump = 1'b1;
            dec.target  = (opcode == OPC_JAL) ? (bus.id_pc + imm_j)
                                              : {jalr_sum[XLEN-1:1], 1'b0};
         end
         OPC_BRANCH: begin
            dec.a         = bus.id_rs1_data;
            dec.b         = bus.id_rs2_data;
            dec.is_branch = 1'b1;
            dec.target    = bus.id_pc + imm_b;
            case (funct3)
               F3_BLT, F3_BGE:   dec.op = ALU_SLT;
               F3_BLTU, F3_BGEU: dec.op = ALU_SLTU;
               default:          dec.op = ALU_SUB;
            endcase
         end
         OPC_LOAD: begin
            dec.op      = ALU_ADD;
            dec.a       = bus.id_rs1_data;
            dec.b       = imm_i;
            dec.wen     = 1'b1;
            dec.is_load = 1'b1;
         end
         OPC_STORE: begin
            dec.op       = ALU_ADD;
            dec.a        = bus.id_rs1_data;
            dec.b        = imm_s;
            dec.is_store = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      if (dec.rd == 5'd0) dec.wen = 1'b0;
   end

   // A redirect in EX means the instruction sitting in ID is wrong-path: load a bubble.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ex_reg <= '0;
      end else if (!bus.ex_stall) begin
         ex_reg <= (bus.id_valid && !redirect) ? dec : '0;
      end
   end

   // SUB gives zero on equality; SLT/SLTU give a nonzero result when A<B.
   always_comb begin
      taken = 1'b0;
      case (ex_reg.f3)
         F3_BEQ, F3_BGE, F3_BGEU: taken = bus.alu_signal[FLAG_ZERO];
         F3_BNE, F3_BLT, F3_BLTU: taken = !bus.alu_signal[FLAG_ZERO];
         default:                 taken = 1'b0;
      endcase
   end

   assign redirect = ex_reg.valid && !bus.ex_stall &&
                     (ex_reg.is_jump || (ex_reg.is_branch && taken));

   assign bus.id_ready       = !bus.ex_stall;
   assign bus.alu_a          = ex_reg.a;
   assign bus.alu_b          = ex_reg.b;
   assign bus.alu_op         = ex_reg.op;
   assign bus.ex_valid       = ex_reg.valid;
   assign bus.ex_rd          = ex_reg.rd;
   assign bus.ex_wen         = ex_reg.wen;
   assign bus.ex_is_load     = ex_reg.is_load;
   assign bus.ex_is_store    = ex_reg.is_store;
   assign bus.ex_illegal     = ex_reg.illegal;
   assign bus.redirect_valid = redirect;
   assign bus.redirect_pc    = ex_reg.target;

   assign unused_flags = ^bus.alu_signal[3:1];

`ifdef ALU_BRANCH_CNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         branch_cnt <= '0;
         taken_cnt  <= '0;
      end else if (ex_reg.valid && !bus.ex_stall && ex_reg.is_branch) begin
         branch_cnt <= branch_cnt + 32'd1;
         if (taken) taken_cnt <= taken_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch: directed RV32I vectors, ALU flag model, queue monitor.
module tb_alu_dispatch;
   import alu_pkg::*;

   typedef struct {
      logic [9:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        wen;
      logic        ld;
      logic        st;
      logic        ill;
      logic        chk_ab;
      logic        redir;
      logic [31:0] rpc;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];
   exp_t none;

   alu_dispatch_if bus ();

`ifdef ALU_BRANCH_CNT_EN
   logic [31:0] branch_cnt, taken_cnt;
   logic [31:0] bc0, tc0;
`endif

   alu_dispatch dut (
      .clk        (clk),
      .rstn       (rstn),
      .bus        (bus)
`ifdef ALU_BRANCH_CNT_EN
      ,
      .branch_cnt (branch_cnt),
      .taken_cnt  (taken_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference ALU producing the flags from the registered operands.
   logic [31:0] res;
   always_comb begin
      res = bus.alu_b;
      case (bus.alu_op)
         ALU_ADD:  res = bus.alu_a + bus.alu_b;
         ALU_SUB:  res = bus.alu_a - bus.alu_b;
         ALU_SLL:  res = bus.alu_a << bus.alu_b[4:0];
         ALU_SLT:  res = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
         ALU_SLTU: res = {31'b0, bus.alu_a < bus.alu_b};
         ALU_XOR:  res = bus.alu_a ^ bus.alu_b;
         ALU_SRL:  res = bus.alu_a >> bus.alu_b[4:0];
         ALU_SRA:  res = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
         ALU_OR:   res = bus.alu_a | bus.alu_b;
         ALU_AND:  res = bus.alu_a & bus.alu_b;
         default:  res = bus.alu_b;
      endcase
   end
   assign bus.alu_signal = {1'b0, bus.alu_a < bus.alu_b, res[31], res == 32'd0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic wen, input logic ld,
                               input logic st, input logic ill, input logic chk_ab,
                               input logic redir, input logic [31:0] rpc);
      exp_t e;
      e.op = op; e.a = a; e.b = b; e.rd = rd; e.wen = wen; e.ld = ld; e.st = st;
      e.ill = ill; e.chk_ab = chk_ab; e.redir = redir; e.rpc = rpc;
      return e;
   endfunction

   task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic push, input exp_t e);
      bus.id_valid    = 1'b1;
      bus.id_instr    = instr;
      bus.id_pc       = pc;
      bus.id_rs1_data = rs1;
      bus.id_rs2_data = rs2;
      if (push) exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rstn && bus.ex_valid && !bus.ex_stall) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_issue", {31'b0, bus.ex_valid}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("txn op=%h a=%h b=%h rd=%0d wen=%0d redir=%0d pc=%h",
                     bus.alu_op, bus.alu_a, bus.alu_b, bus.ex_rd, bus.ex_wen,
                     bus.redirect_valid, bus.redirect_pc);
            chk("alu_op", {22'b0, bus.alu_op}, {22'b0, e.op});
            if (e.chk_ab) begin
               chk("alu_a", bus.alu_a, e.a);
               chk("alu_b", bus.alu_b, e.b);
            end
            chk("ex_rd", {27'b0, bus.ex_rd}, {27'b0, e.rd});
            chk("ex_wen", {31'b0, bus.ex_wen}, {31'b0, e.wen});
            chk("ex_is_load", {31'b0, bus.ex_is_load}, {31'b0, e.ld});
            chk("ex_is_store", {31'b0, bus.ex_is_store}, {31'b0, e.st});
            chk("ex_illegal", {31'b0, bus.ex_illegal}, {31'b0, e.ill});
            chk("redirect_valid", {31'b0, bus.redirect_valid}, {31'b0, e.redir});
            if (e.redir) chk("redirect_pc", bus.redirect_pc, e.rpc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   localparam logic [31:0] I_ADD  = 32'h002081B3; // add x3,x1,x2
   localparam logic [31:0] I_SRAI = 32'h4030D213; // srai x4,x1,3
   localparam logic [31:0] I_OR0  = 32'h0020E033; // or x0,x1,x2
   localparam logic [31:0] I_BEQ  = 32'h00208863; // beq x1,x2,+16
   localparam logic [31:0] I_BLT  = 32'h0020C463; // blt x1,x2,+8
   localparam logic [31:0] I_BLTU = 32'h0020E463; // bltu x1,x2,+8
   localparam logic [31:0] I_JALR = 32'h000280E7; // jalr x1,0(x5)
   localparam logic [31:0] I_JAL  = 32'h020000EF; // jal x1,+32
   localparam logic [31:0] I_LW   = 32'hFFC0A303; // lw x6,-4(x1)
   localparam logic [31:0] I_SW   = 32'h0020A423; // sw x2,8(x1)
   localparam logic [31:0] I_BAD  = 32'h0000007F;
   localparam logic [31:0] I_BNE  = 32'h00209663; // bne x1,x2,+12

   initial begin
      none = mk(10'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.ex_stall    = 1'b0;
      bus.id_valid    = 1'b1;
      bus.id_instr    = I_ADD;
      bus.id_pc       = 32'h0;
      bus.id_rs1_data = 32'd5;
      bus.id_rs2_data = 32'd7;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_alu_op", {22'b0, bus.alu_op}, 32'd0);
      chk("rst_alu_a", bus.alu_a, 32'd0);
      chk("rst_alu_b", bus.alu_b, 32'd0);
      chk("rst_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
      chk("rst_ex_wen", {31'b0, bus.ex_wen}, 32'd0);
      chk("rst_ex_rd", {27'b0, bus.ex_rd}, 32'd0);
      chk("rst_redirect", {31'b0, bus.redirect_valid}, 32'd0);
      chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
`ifdef ALU_BRANCH_CNT_EN
      chk("rst_branch_cnt", branch_cnt, 32'd0);
      chk("rst_taken_cnt", taken_cnt, 32'd0);
`endif
      rstn = 1'b1;

      issue(I_ADD, 32'h0, 32'd5, 32'd7, 1, mk(ALU_ADD, 5, 7, 3, 1, 0, 0, 0, 1, 0, 0));
      issue(I_SRAI, 32'h4, 32'h80000000, 32'd0, 1,
            mk(ALU_SRA, 32'h80000000, 3, 4, 1, 0, 0, 0, 1, 0, 0));
      issue(I_OR0, 32'h8, 32'h0F0, 32'h00F, 1, mk(ALU_OR, 32'h0F0, 32'h00F, 0, 0, 0, 0, 0, 1, 0, 0));
      issue(I_BEQ, 32'h100, 32'd9, 32'd9, 1, mk(ALU_SUB, 9, 9, 16, 0, 0, 0, 0, 1, 1, 32'h110));
      issue(I_ADD, 32'h104, 32'd1, 32'd1, 0, none);
      issue(I_BLT, 32'h200, 32'hFFFFFFFF, 32'd1, 1,
            mk(ALU_SLT, 32'hFFFFFFFF, 1, 8, 0, 0, 0, 0, 1, 1, 32'h208));
      issue(I_ADD, 32'h204, 32'd1, 32'd1, 0, none);
      issue(I_BLTU, 32'h300, 32'hFFFFFFFF, 32'd1, 1,
            mk(ALU_SLTU, 32'hFFFFFFFF, 1, 8, 0, 0, 0, 0, 1, 0, 0));
      issue(I_ADD, 32'h304, 32'd20, 32'd22, 1, mk(ALU_ADD, 20, 22, 3, 1, 0, 0, 0, 1, 0, 0));
      issue(I_JALR, 32'h400, 32'h203, 32'd0, 1, mk(ALU_ADD, 32'h400, 4, 1, 1, 0, 0, 0, 1, 1, 32'h202));
      issue(I_ADD, 32'h404, 32'd1, 32'd1, 0, none);
      issue(I_JAL, 32'h500, 32'd0, 32'd0, 1, mk(ALU_ADD, 32'h500, 4, 1, 1, 0, 0, 0, 1, 1, 32'h520));
      issue(I_ADD, 32'h504, 32'd1, 32'd1, 0, none);
      issue(I_LW, 32'h520, 32'h1000, 32'd0, 1,
            mk(ALU_ADD, 32'h1000, 32'hFFFFFFFC, 6, 1, 1, 0, 0, 1, 0, 0));
      issue(I_SW, 32'h524, 32'h1000, 32'd0, 1, mk(ALU_ADD, 32'h1000, 8, 8, 0, 0, 1, 0, 1, 0, 0));
      issue(I_BAD, 32'h528, 32'd3, 32'd4, 1, mk(ALU_PASS, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

`ifdef ALU_BRANCH_CNT_EN
      bc0 = branch_cnt;
      tc0 = taken_cnt;
`endif
      // Taken BNE held in EX by a three-cycle stall.
      issue(I_BNE, 32'h600, 32'd1, 32'd2, 1, mk(ALU_SUB, 1, 2, 12, 0, 0, 0, 0, 1, 1, 32'h60C));
      bus.ex_stall = 1'b1;
      bus.id_instr = I_ADD;
      bus.id_pc    = 32'h604;
      #1;
      chk("stall_id_ready", {31'b0, bus.id_ready}, 32'd0);
      chk("stall_redirect", {31'b0, bus.redirect_valid}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("stall_alu_op", {22'b0, bus.alu_op}, {22'b0, ALU_SUB});
         chk("stall_alu_a", bus.alu_a, 32'd1);
         chk("stall_ex_valid", {31'b0, bus.ex_valid}, 32'd1);
         chk("stall_redirect", {31'b0, bus.redirect_valid}, 32'd0);
      end
      bus.ex_stall = 1'b0;
      #1;
      chk("release_redirect", {31'b0, bus.redirect_valid}, 32'd1);
      chk("release_id_ready", {31'b0, bus.id_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("after_release_redirect", {31'b0, bus.redirect_valid}, 32'd0);
      chk("after_release_bubble", {31'b0, bus.ex_valid}, 32'd0);
`ifdef ALU_BRANCH_CNT_EN
      chk("stall_branch_cnt_delta", branch_cnt - bc0, 32'd1);
      chk("stall_taken_cnt_delta", taken_cnt - tc0, 32'd1);
      chk("branch_cnt_total", branch_cnt, 32'd4);
      chk("taken_cnt_total", taken_cnt, 32'd3);
`endif

      bus.id_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", exp_q.size(), 32'd0);

      // Asynchronous reset while a valid instruction sits in EX.
      issue(I_ADD, 32'h700, 32'd5, 32'd7, 0, none);
      bus.id_valid = 1'b0;
      chk("pre_reset_ex_valid", {31'b0, bus.ex_valid}, 32'd1);
      #1;
      rstn = 1'b0;
      #1;
      chk("async_rst_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
      chk("async_rst_alu_a", bus.alu_a, 32'd0);
      chk("async_rst_ex_wen", {31'b0, bus.ex_wen}, 32'd0);
      chk("async_rst_redirect", {31'b0, bus.redirect_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
